// File: rtl/md_alu.sv
// Combinational ALU with comparison flags plus a multi-cycle multiply/divide
// unit that writes its result into the hi/lo register pair.
module md_alu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_cmp,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic [WIDTH-1:0] Y,
  output logic             Greater,
  output logic             Equal,
  output logic             Less,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SH_W    = $clog2(WIDTH);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         mdop_q, mdop_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [SH_W-1:0]    shamt;
  logic               signed_lt, unsigned_lt;
  logic [WIDTH-1:0]   y_res;

  assign shamt       = A[SH_W-1:0];
  assign signed_lt   = $signed(A) < $signed(B);
  assign unsigned_lt = A < B;

  always_comb begin
    y_res = '0;
    case (op)
      4'd0:    y_res = A + B;
      4'd1:    y_res = A - B;
      4'd2:    y_res = A | B;
      4'd3:    y_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd4:    y_res = A ^ B;
      4'd5:    y_res = A & B;
      4'd6:    y_res = ~(A | B);
      4'd7:    y_res = {{(WIDTH-1){1'b0}}, signed_lt};
      4'd8:    y_res = {{(WIDTH-1){1'b0}}, unsigned_lt};
      4'd9:    y_res = B << shamt;
      4'd10:   y_res = B >> shamt;
      4'd11:   y_res = $unsigned($signed(B) >>> shamt);
      4'd12:   y_res = hi_q;
      4'd13:   y_res = lo_q;
      default: y_res = '0;
    endcase
  end

  assign Y       = y_res;
  assign Equal   = (A == B);
  assign Less    = signed_cmp ? signed_lt : unsigned_lt;
  assign Greater = ~Equal & ~Less;

  // Multiply: sign- or zero-extend both latched operands to the full product width.
  logic               ext_sign;
  logic [2*WIDTH-1:0] prod;
  assign ext_sign = ~mdop_q[0];
  assign prod = {{WIDTH{ext_sign & a_q[WIDTH-1]}}, a_q} *
                {{WIDTH{ext_sign & b_q[WIDTH-1]}}, b_q};

  // Signed divide works on magnitudes, then restores signs (truncation toward zero).
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b, den, q_mag, r_mag, quot, rem;
  assign a_neg = ~mdop_q[0] & a_q[WIDTH-1];
  assign b_neg = ~mdop_q[0] & b_q[WIDTH-1];
  assign abs_a = a_neg ? -a_q : a_q;
  assign abs_b = b_neg ? -b_q : b_q;
  assign den   = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
  assign q_mag = abs_a / den;
  assign r_mag = abs_a % den;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mdop_d  = mdop_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          mdop_d  = md_op;
          cnt_d   = md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          state_d = RUN;
        end else begin
          if (wr_hi) hi_d = A;
          if (wr_lo) lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!mdop_q[1]) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mdop_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mdop_q  <= mdop_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_alu.sv
// Directed self-checking bench for md_alu: ALU ops, flags, multiply/divide
// timing and results, hi/lo writes and reset abort.
module tb_md_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        signed_cmp = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  md_op = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] Y;
  logic        Greater, Equal, Less, busy;
  logic [31:0] hi, lo;

  int numVectors = 0;
  int numMiscompares = 0;
  int cyc;

  md_alu #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .op(op), .A(A), .B(B), .signed_cmp(signed_cmp),
    .start(start), .md_op(md_op), .wr_hi(wr_hi), .wr_lo(wr_lo), .Y(Y),
    .Greater(Greater), .Equal(Equal), .Less(Less), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numVectors++;
    if (got !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic s);
    op = o; A = a; B = b; signed_cmp = s;
    #1;
  endtask

  // Starts an operation, re-requests with altered operands mid-run and counts busy cycles.
  task automatic runMulDiv(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] prevHi, output int cycles);
    cycles = 0;
    op = 4'd12; A = a; B = b; md_op = m; start = 1'b1;
    step();
    if (busy) cycles++;
    checkOutput("y_hi_during_busy", Y, prevHi);
    A = ~a; B = b ^ 32'h55; md_op = ~m;
    step();
    start = 1'b0;
    while (busy && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_hi", hi, 32'h0);
    checkOutput("rst_lo", lo, 32'h0);

    applyStimulus(4'd1, 32'd3, 32'd5, 1'b0);           checkOutput("sub", Y, 32'hFFFFFFFE);
    applyStimulus(4'd0, 32'hFFFFFFFF, 32'd1, 1'b0);    checkOutput("add_wrap", Y, 32'h0);
    applyStimulus(4'd2, 32'h0000F0F0, 32'h00000F0F, 1'b0); checkOutput("or", Y, 32'h0000FFFF);
    applyStimulus(4'd3, 32'h0, 32'h1234ABCD, 1'b0);    checkOutput("lui", Y, 32'hABCD0000);
    applyStimulus(4'd4, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0); checkOutput("xor", Y, 32'hF00FF00F);
    applyStimulus(4'd5, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0); checkOutput("and", Y, 32'h0F000F00);
    applyStimulus(4'd6, 32'h0, 32'h0, 1'b0);           checkOutput("nor", Y, 32'hFFFFFFFF);
    applyStimulus(4'd7, 32'hFFFFFFFF, 32'd1, 1'b0);    checkOutput("slt", Y, 32'h1);
    applyStimulus(4'd8, 32'hFFFFFFFF, 32'd1, 1'b0);    checkOutput("sltu", Y, 32'h0);
    applyStimulus(4'd9, 32'd35, 32'd1, 1'b0);          checkOutput("sll", Y, 32'h8);
    applyStimulus(4'd10, 32'd4, 32'h80000000, 1'b0);   checkOutput("srl", Y, 32'h08000000);
    applyStimulus(4'd11, 32'd4, 32'h80000000, 1'b0);   checkOutput("sra", Y, 32'hF8000000);
    applyStimulus(4'd14, 32'd4, 32'h80000000, 1'b0);   checkOutput("op14", Y, 32'h0);
    applyStimulus(4'd0, 32'hFFFFFFFF, 32'd1, 1'b1);
    checkOutput("flags_signed", {29'b0, Greater, Equal, Less}, 32'h1);
    applyStimulus(4'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    checkOutput("flags_unsigned", {29'b0, Greater, Equal, Less}, 32'h4);
    applyStimulus(4'd0, 32'd5, 32'd5, 1'b1);
    checkOutput("flags_equal", {29'b0, Greater, Equal, Less}, 32'h2);

    runMulDiv(2'b00, 32'hFFFFFFFD, 32'd7, 32'h0, cyc);
    checkOutput("mult_cycles", cyc, 32'd5);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFEB);
    step();
    checkOutput("no_queued_start", {31'b0, busy}, 32'h0);

    runMulDiv(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, cyc);
    checkOutput("div_cycles", cyc, 32'd10);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);

    runMulDiv(2'b11, 32'd5, 32'd0, 32'hFFFFFFFF, cyc);
    checkOutput("div0_cycles", cyc, 32'd10);
    checkOutput("div0_lo", lo, 32'hFFFFFFFD);
    checkOutput("div0_hi", hi, 32'hFFFFFFFF);

    runMulDiv(2'b11, 32'd100, 32'd7, 32'hFFFFFFFF, cyc);
    checkOutput("divu_lo", lo, 32'd14);
    checkOutput("divu_hi", hi, 32'd2);

    runMulDiv(2'b10, 32'd7, 32'hFFFFFFFE, 32'd2, cyc);
    checkOutput("div_negb_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_negb_hi", hi, 32'd1);

    runMulDiv(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd1, cyc);
    checkOutput("div_ovf_lo", lo, 32'h80000000);
    checkOutput("div_ovf_hi", hi, 32'h0);

    runMulDiv(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, cyc);
    checkOutput("multu_cycles", cyc, 32'd5);
    checkOutput("multu_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", lo, 32'h00000001);

    A = 32'h1234; wr_hi = 1'b1; wr_lo = 1'b1;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
    checkOutput("wr_hi", hi, 32'h1234);
    checkOutput("wr_lo", lo, 32'h1234);
    A = 32'hAAAA; wr_hi = 1'b1;
    step();
    wr_hi = 1'b0;
    checkOutput("wr_hi_only", hi, 32'hAAAA);
    checkOutput("wr_lo_kept", lo, 32'h1234);

    A = 32'h5678; B = 32'd2; md_op = 2'b01; start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1;
    step();
    start = 1'b0; wr_lo = 1'b0;
    A = 32'h9999;
    checkOutput("start_wins_busy", {31'b0, busy}, 32'h1);
    checkOutput("start_wins_hi", hi, 32'hAAAA);
    checkOutput("start_wins_lo", lo, 32'h1234);
    step();
    wr_hi = 1'b0;
    checkOutput("wr_while_busy", hi, 32'hAAAA);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
    checkOutput("mix_done", {31'b0, busy}, 32'h0);
    checkOutput("mix_hi", hi, 32'h0);
    checkOutput("mix_lo", lo, 32'h0000ACF0);

    A = 32'hBEEF; wr_hi = 1'b1;
    step();
    wr_hi = 1'b0;
    A = 32'hFFFFFFF9; B = 32'd2; md_op = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    checkOutput("abort_hi", hi, 32'h0);
    checkOutput("abort_lo", lo, 32'h0);
    for (int i = 0; i < 12; i++) step();
    checkOutput("abort_busy_later", {31'b0, busy}, 32'h0);
    checkOutput("abort_hi_later", hi, 32'h0);
    checkOutput("abort_lo_later", lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/md_alu.md
MD_ALU -- requirements
Module: md_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning datapath width of A, B, Y, hi, lo (even, >=8).
REQ-002 SHALL provide parameter MUL_LAT, default 5, meaning busy cycles per multiply (>=1).
REQ-003 SHALL provide parameter DIV_LAT, default 10, meaning busy cycles per divide (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port op  input  4  combinational operation select.
REQ-007 SHALL have ports A and B  input  WIDTH  operands.
REQ-008 SHALL have port signed_cmp  input  1  selects signed (1) or unsigned (0) flag comparison.
REQ-009 SHALL have port start  input  1  request a multiply/divide.
REQ-010 SHALL have port md_op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-011 SHALL have ports wr_hi and wr_lo  input  1  load A into hi / lo.
REQ-012 SHALL have port Y  output  WIDTH  combinational result.
REQ-013 SHALL have ports Greater, Equal, Less  output  1  comparison flags of A vs B.
REQ-014 SHALL have port busy  output  1  multiply/divide in progress.
REQ-015 SHALL have ports hi and lo  output  WIDTH  registered result registers.

Function
REQ-016 Y SHALL be: 0 A+B, 1 A-B, 2 A|B, 3 {B[WIDTH/2-1:0], WIDTH/2 zeros}, 4 A^B, 5 A&B, 6 ~(A|B), 7 signed A<B ? 1:0, 8 unsigned A<B ? 1:0, 9 B<<A[log2(WIDTH)-1:0], 10 logical B>>shamt, 11 arithmetic B>>>shamt, 12 hi, 13 lo, 14-15 zero; add/sub wrap modulo 2^WIDTH.
REQ-017 Greater/Less SHALL compare signed when signed_cmp=1, unsigned otherwise; Equal SHALL be bitwise equality; exactly one flag high.
REQ-018 Controller SHALL have states IDLE and RUN plus a cycle counter; busy=1 exactly in RUN.
REQ-019 In IDLE, start=1 at an edge SHALL latch A, B, md_op, enter RUN, and load counter with MUL_LAT (md_op[1]=0) or DIV_LAT (md_op[1]=1).
REQ-020 busy SHALL remain high for exactly the loaded number of cycles; on the edge ending the last busy cycle, state SHALL return to IDLE and hi/lo SHALL update in the same edge.
REQ-021 Multiply SHALL write the 2*WIDTH product of latched operands, signed for mult, unsigned for multu: hi=upper half, lo=lower half.
REQ-022 Divide SHALL write lo=quotient, hi=remainder; signed div truncates toward zero, remainder takes dividend sign.
REQ-023 Signed div of most-negative value by -1 SHALL give lo=most-negative, hi=0.
REQ-024 Divide by zero SHALL still hold busy for DIV_LAT cycles and SHALL leave hi and lo unchanged.
REQ-025 start asserted while busy SHALL be ignored, not queued; A/B changes during RUN SHALL not affect the result.
REQ-026 wr_hi/wr_lo in IDLE SHALL load A into hi/lo at the edge; both may be set together; ignored while busy.
REQ-027 start and wr_hi/wr_lo in the same IDLE cycle: start SHALL win, writes ignored.
REQ-028 Y and flags SHALL stay functional while busy; ops 12/13 return current (pre-completion) hi/lo.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, busy=0, counter=0, hi=0, lo=0, with priority over start and writes.
REQ-030 reset during RUN SHALL abort the operation; no hi/lo update SHALL occur afterward.
REQ-031 Y and flags are combinational and SHALL not depend on reset except through hi/lo.

Verification
REQ-032 op=1, A=3, B=5 -> Y=32'hFFFFFFFE; signed_cmp=1, A=-1, B=1 -> Less=1; signed_cmp=0 -> Greater=1.
REQ-033 start, md_op=00, A=-3, B=7 -> busy high 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-034 start, md_op=10, A=-7, B=2 -> busy high 10 cycles; then lo=-3, hi=-1; md_op=11, B=0 -> hi/lo unchanged.
REQ-035 second start during busy, A changed mid-RUN -> single result from first operands; busy not extended.
REQ-036 reset asserted in cycle 3 of a divide -> busy=0, hi=lo=0 next cycle, and remain 0 thereafter.
REQ-037 IDLE, wr_hi=1, wr_lo=1, A=32'h1234 -> hi=lo=32'h1234; with start=1 same cycle -> writes dropped, busy=1.
